// File: rtl/pwm_setpoint_ramp.sv
// pwm_setpoint_ramp: double-buffered PWM setpoints applied at period boundaries, with soft-start duty ramping
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   io_enable    in   1 = tick and ramp, 0 = idle with duty and phase forced to 0
//   io_cfg_*     in   setpoint offer (valid, period T, target duty, prescale div)
//   io_cfg_ready out  pending slot empty
//   io_inc       out  one-cycle tick every div+1 clocks
//   io_T         out  active period
//   io_duty      out  ramped duty
//   io_phase     out  position within the period
//   io_busy      out  duty still ramping toward target
//   io_err       out  sticky flag for a rejected setpoint
module pwm_setpoint_ramp #(
   parameter int WIDTH   = 8,
   parameter int PRESC_W = 8,
   parameter int STEP    = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               io_enable,
   input  logic               io_cfg_valid,
   output logic               io_cfg_ready,
   input  logic [WIDTH-1:0]   io_cfg_T,
   input  logic [WIDTH-1:0]   io_cfg_duty,
   input  logic [PRESC_W-1:0] io_cfg_div,
   output logic               io_inc,
   output logic [WIDTH-1:0]   io_T,
   output logic [WIDTH-1:0]   io_duty,
   output logic [WIDTH-1:0]   io_phase,
   output logic               io_busy,
   output logic               io_err
);
   typedef enum logic [1:0] {IDLE, RUN, RAMP} state_t;
   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
   state_t state, state_n;
   logic [WIDTH-1:0] target, pend_t, pend_duty;
   logic [PRESC_W-1:0] div, presc, pend_div;
   logic pend, take, legal, wrap, apply, up;
   logic [WIDTH-1:0] t_next, target_next, clamp, gap, mv, stepped, duty_n, phase_n;
   logic [PRESC_W-1:0] div_next, presc_n;
   always_comb begin
      io_cfg_ready = !pend;
      io_busy = state == RAMP;
      io_inc = state != IDLE && io_enable && presc == div;
      take = io_cfg_valid && !pend;
      legal = io_cfg_T != '0 && io_cfg_duty <= io_cfg_T;
      wrap = io_inc && io_phase == io_T - WIDTH'(1);
      apply = pend && (state == IDLE || wrap);
      t_next = apply ? pend_t : io_T;
      target_next = apply ? pend_duty : target;
      div_next = apply ? pend_div : div;
      // a shorter new period clamps duty first, then the ramp step is taken from there
      clamp = io_duty > t_next ? t_next : io_duty;
      up = target_next > clamp;
      gap = up ? target_next - clamp : clamp - target_next;
      mv = gap > STEP_W ? STEP_W : gap;
      stepped = up ? clamp + mv : clamp - mv;
      state_n = state;
      duty_n = '0;
      phase_n = '0;
      presc_n = '0;
      if (state == IDLE)
         // io_T != 0 means a setpoint was applied before, so re-enable restarts without a new offer
         state_n = io_enable && (pend || io_T != '0) ? (target_next != '0 ? RAMP : RUN) : IDLE;
      else if (!io_enable)
         state_n = IDLE;
      else begin
         presc_n = io_inc ? '0 : presc + PRESC_W'(1);
         phase_n = wrap ? '0 : io_phase + WIDTH'(io_inc);
         duty_n = wrap ? stepped : io_duty;
         state_n = wrap ? (stepped == target_next ? RUN : RAMP) : state;
      end
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         io_T <= '0;
         io_duty <= '0;
         io_phase <= '0;
         target <= '0;
         div <= '0;
         presc <= '0;
         pend <= 1'b0;
         pend_t <= '0;
         pend_duty <= '0;
         pend_div <= '0;
         io_err <= 1'b0;
      end else begin
         state <= state_n;
         io_T <= t_next;
         target <= target_next;
         div <= div_next;
         io_duty <= duty_n;
         io_phase <= phase_n;
         presc <= presc_n;
         pend <= take ? legal : pend && !apply;
         io_err <= io_err || (take && !legal);
         if (take && legal) begin
            pend_t <= io_cfg_T;
            pend_duty <= io_cfg_duty;
            pend_div <= io_cfg_div;
         end
      end
   end
endmodule

// File: tb/tb_pwm_setpoint_ramp.sv
// tb_pwm_setpoint_ramp: scenario and random checks of pwm_setpoint_ramp against a behavioural model
module tb_pwm_setpoint_ramp;
   localparam int W = 8, PW = 8, STEP = 1;
   logic clock = 0, reset = 1, enable = 0, cfg_valid = 0;
   logic [W-1:0] cfg_T = 0, cfg_duty = 0;
   logic [PW-1:0] cfg_div = 0;
   logic io_cfg_ready, io_inc, io_busy, io_err;
   logic [W-1:0] io_T, io_duty, io_phase;
   int tests = 0, fails = 0;
   int m_T, m_duty, m_tgt, m_div, m_phase, m_pc, m_pT, m_pd, m_pdv;
   bit m_pend, m_err, m_act;

   pwm_setpoint_ramp #(.WIDTH(W), .PRESC_W(PW), .STEP(STEP)) dut (
      .clock(clock), .reset(reset), .io_enable(enable), .io_cfg_valid(cfg_valid),
      .io_cfg_ready(io_cfg_ready), .io_cfg_T(cfg_T), .io_cfg_duty(cfg_duty), .io_cfg_div(cfg_div),
      .io_inc(io_inc), .io_T(io_T), .io_duty(io_duty), .io_phase(io_phase),
      .io_busy(io_busy), .io_err(io_err));

   always #5 clock = ~clock;

   function automatic bit m_inc();
      return m_act && enable && m_pc == m_div;
   endfunction

   function automatic bit m_busy();
      return m_act && m_duty != m_tgt;
   endfunction

   task automatic model_reset();
      m_T = 0; m_duty = 0; m_tgt = 0; m_div = 0; m_phase = 0; m_pc = 0;
      m_pT = 0; m_pd = 0; m_pdv = 0; m_pend = 0; m_err = 0; m_act = 0;
   endtask

   // one clock edge of the behavioural model, using the inputs as they stand before the edge
   task automatic model_edge();
      bit inc, wrap, take, legal, apply;
      take = cfg_valid && !m_pend;
      legal = cfg_T != 0 && cfg_duty <= cfg_T;
      inc = m_inc();
      wrap = inc && m_phase == m_T - 1;
      apply = m_pend && (!m_act || wrap);
      if (apply) begin
         m_T = m_pT; m_tgt = m_pd; m_div = m_pdv;
      end
      if (!m_act) begin
         m_duty = 0; m_phase = 0; m_pc = 0;
         m_act = enable && m_T != 0;
      end else if (!enable) begin
         m_act = 0; m_duty = 0; m_phase = 0; m_pc = 0;
      end else begin
         m_pc = inc ? 0 : m_pc + 1;
         if (inc) m_phase = wrap ? 0 : m_phase + 1;
         if (wrap) begin
            if (m_duty > m_T) m_duty = m_T;
            if (m_duty < m_tgt) m_duty = (m_duty + STEP > m_tgt) ? m_tgt : m_duty + STEP;
            else if (m_duty > m_tgt) m_duty = (m_duty - STEP < m_tgt) ? m_tgt : m_duty - STEP;
         end
      end
      if (take) begin
         if (legal) begin
            m_pend = 1; m_pT = cfg_T; m_pd = cfg_duty; m_pdv = cfg_div;
         end else m_err = 1;
      end else if (apply) m_pend = 0;
   endtask

   task automatic step();
      @(posedge clock);
      if (!reset) model_reset();
      else model_edge();
      #1;
   endtask

   task automatic offer(input int t, input int d, input int dv, output bit acc);
      cfg_T = W'(t); cfg_duty = W'(d); cfg_div = PW'(dv); cfg_valid = 1; acc = 0;
      for (int i = 0; i < 300 && !acc; i++) begin
         acc = !m_pend;
         step();
      end
      cfg_valid = 0;
   endtask

   task automatic test_reset();
      #2 reset = 0;
      #1;
      tests++; if (io_T !== 0 || io_duty !== 0 || io_phase !== 0) begin fails++; $display("FAIL reset_regs got T=%0d duty=%0d phase=%0d exp 0 0 0", io_T, io_duty, io_phase); end
      tests++; if (io_inc !== 0 || io_busy !== 0 || io_err !== 0) begin fails++; $display("FAIL reset_flags got inc=%0b busy=%0b err=%0b exp 0 0 0", io_inc, io_busy, io_err); end
      tests++; if (io_cfg_ready !== 1) begin fails++; $display("FAIL reset_ready got %0b exp 1", io_cfg_ready); end
      step(); step();
      reset = 1;
   endtask

   task automatic test_ramp();
      bit acc;
      int exp_d;
      enable = 1;
      offer(9, 4, 0, acc);
      tests++; if (!acc) begin fails++; $display("FAIL ramp_accept got 0 exp 1"); end
      tests++; if (io_cfg_ready !== 0) begin fails++; $display("FAIL ramp_ready_full got %0b exp 0", io_cfg_ready); end
      step();
      tests++; if (io_T !== 9 || io_duty !== 0) begin fails++; $display("FAIL ramp_load got T=%0d duty=%0d exp 9 0", io_T, io_duty); end
      for (int k = 1; k <= 40; k++) begin
         step();
         exp_d = (k / 9 > 4) ? 4 : k / 9;
         tests++; if (io_duty !== W'(exp_d)) begin fails++; $display("FAIL ramp_duty k=%0d got %0d exp %0d", k, io_duty, exp_d); end
         tests++; if (io_busy !== (k < 36)) begin fails++; $display("FAIL ramp_busy k=%0d got %0b exp %0b", k, io_busy, k < 36); end
         tests++; if (io_phase !== W'(m_phase) || io_inc !== m_inc()) begin fails++; $display("FAIL ramp_phase k=%0d got %0d/%0b exp %0d/%0b", k, io_phase, io_inc, m_phase, m_inc()); end
      end
   endtask

   task automatic test_prescale();
      bit acc;
      int last = -1, gap = 0, cnt = 0, last_cnt = 0;
      logic [W-1:0] prev;
      offer(9, 4, 2, acc);
      tests++; if (!acc) begin fails++; $display("FAIL presc_accept got 0 exp 1"); end
      prev = io_phase;
      for (int i = 0; i < 100; i++) begin
         step();
         tests++; if (io_inc !== m_inc() || io_phase !== W'(m_phase)) begin fails++; $display("FAIL presc_tick i=%0d got %0b/%0d exp %0b/%0d", i, io_inc, io_phase, m_inc(), m_phase); end
         if (prev == 8 && io_phase == 0) begin
            if (last >= 0) gap = i - last;
            last = i; last_cnt = cnt; cnt = 0;
         end
         cnt += int'(io_inc);
         prev = io_phase;
      end
      tests++; if (gap !== 27) begin fails++; $display("FAIL presc_period got %0d exp 27", gap); end
      tests++; if (last_cnt !== 9) begin fails++; $display("FAIL presc_ticks got %0d exp 9", last_cnt); end
      tests++; if (io_duty !== 4 || io_busy !== 0) begin fails++; $display("FAIL presc_duty got %0d/%0b exp 4/0", io_duty, io_busy); end
   endtask

   task automatic test_err();
      bit acc;
      offer(9, 10, 0, acc);
      tests++; if (io_err !== 1 || io_cfg_ready !== 1) begin fails++; $display("FAIL err_set got err=%0b ready=%0b exp 1 1", io_err, io_cfg_ready); end
      tests++; if (io_T !== 9 || io_duty !== 4) begin fails++; $display("FAIL err_keep got T=%0d duty=%0d exp 9 4", io_T, io_duty); end
      offer(0, 0, 0, acc);
      for (int i = 0; i < 30; i++) step();
      tests++; if (io_err !== 1 || io_T !== 9 || io_cfg_ready !== 1) begin fails++; $display("FAIL err_sticky got err=%0b T=%0d ready=%0b exp 1 9 1", io_err, io_T, io_cfg_ready); end
   endtask

   task automatic test_back_to_back();
      bit acc;
      offer(8, 6, 0, acc);
      tests++; if (io_cfg_ready !== 0) begin fails++; $display("FAIL b2b_ready got %0b exp 0", io_cfg_ready); end
      offer(9, 6, 0, acc);
      tests++; if (!acc || io_T !== 8 || io_cfg_ready !== 0) begin fails++; $display("FAIL b2b_second got acc=%0b T=%0d ready=%0b exp 1 8 0", acc, io_T, io_cfg_ready); end
      for (int i = 0; i < 100 && io_T != 9; i++) step();
      tests++; if (io_T !== 9 || io_cfg_ready !== 1) begin fails++; $display("FAIL b2b_apply got T=%0d ready=%0b exp 9 1", io_T, io_cfg_ready); end
      for (int i = 0; i < 30; i++) step();
      tests++; if (io_duty !== 6 || io_busy !== 0) begin fails++; $display("FAIL b2b_settle got %0d/%0b exp 6/0", io_duty, io_busy); end
   endtask

   task automatic test_clamp();
      bit acc;
      offer(4, 2, 0, acc);
      for (int i = 0; i < 30 && io_T == 9; i++) step();
      tests++; if (io_T !== 4 || io_duty !== 3 || io_busy !== 1) begin fails++; $display("FAIL clamp_apply got T=%0d duty=%0d busy=%0b exp 4 3 1", io_T, io_duty, io_busy); end
      step(); step(); step();
      tests++; if (io_duty !== 3) begin fails++; $display("FAIL clamp_hold got %0d exp 3", io_duty); end
      step();
      tests++; if (io_duty !== 2 || io_busy !== 0) begin fails++; $display("FAIL clamp_settle got %0d/%0b exp 2/0", io_duty, io_busy); end
   endtask

   task automatic test_enable();
      enable = 0;
      step();
      tests++; if (io_duty !== 0 || io_phase !== 0 || io_T !== 4 || io_busy !== 0) begin fails++; $display("FAIL dis_idle got duty=%0d phase=%0d T=%0d busy=%0b exp 0 0 4 0", io_duty, io_phase, io_T, io_busy); end
      step(); step();
      tests++; if (io_inc !== 0) begin fails++; $display("FAIL dis_inc got %0b exp 0", io_inc); end
      enable = 1;
      step();
      tests++; if (io_duty !== 0 || io_busy !== 1) begin fails++; $display("FAIL ena_start got %0d/%0b exp 0/1", io_duty, io_busy); end
      for (int i = 0; i < 7; i++) step();
      tests++; if (io_duty !== 1) begin fails++; $display("FAIL ena_ramp got %0d exp 1", io_duty); end
      step();
      tests++; if (io_duty !== 2 || io_busy !== 0) begin fails++; $display("FAIL ena_settle got %0d/%0b exp 2/0", io_duty, io_busy); end
   endtask

   task automatic test_reset_mid();
      bit acc;
      reset = 0;
      step(); step();
      reset = 1;
      offer(9, 4, 0, acc);
      for (int i = 0; i < 100 && m_duty != 2; i++) step();
      tests++; if (io_duty !== 2 || io_busy !== 1) begin fails++; $display("FAIL mid_pre got %0d/%0b exp 2/1", io_duty, io_busy); end
      #2 reset = 0;
      #1;
      tests++; if (io_T !== 0 || io_duty !== 0 || io_phase !== 0 || io_inc !== 0) begin fails++; $display("FAIL mid_regs got T=%0d duty=%0d phase=%0d inc=%0b exp 0 0 0 0", io_T, io_duty, io_phase, io_inc); end
      tests++; if (io_busy !== 0 || io_err !== 0 || io_cfg_ready !== 1) begin fails++; $display("FAIL mid_flags got busy=%0b err=%0b ready=%0b exp 0 0 1", io_busy, io_err, io_cfg_ready); end
      step();
      reset = 1;
   endtask

   task automatic test_random();
      int t;
      for (int i = 0; i < 3000; i++) begin
         step();
         tests++; if (io_T !== W'(m_T) || io_duty !== W'(m_duty) || io_phase !== W'(m_phase)) begin fails++; $display("FAIL rnd_regs i=%0d got %0d/%0d/%0d exp %0d/%0d/%0d", i, io_T, io_duty, io_phase, m_T, m_duty, m_phase); end
         tests++; if (io_inc !== m_inc() || io_busy !== m_busy()) begin fails++; $display("FAIL rnd_inc_busy i=%0d got %0b/%0b exp %0b/%0b", i, io_inc, io_busy, m_inc(), m_busy()); end
         tests++; if (io_err !== m_err || io_cfg_ready !== !m_pend) begin fails++; $display("FAIL rnd_err_ready i=%0d got %0b/%0b exp %0b/%0b", i, io_err, io_cfg_ready, m_err, !m_pend); end
         if ($urandom_range(0, 149) == 0) enable = ~enable;
         cfg_valid = $urandom_range(0, 3) == 0;
         t = $urandom_range(0, 20);
         cfg_T = W'(t);
         cfg_duty = W'($urandom_range(0, t + 2));
         cfg_div = PW'($urandom_range(0, 3));
      end
      cfg_valid = 0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_ramp();
      test_prescale();
      test_err();
      test_back_to_back();
      test_clamp();
      test_enable();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
